// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter
//   Arbitrates one single-port, word-addressed instruction RAM (1-cycle
//   synchronous read) between the CPU fetch port (F, read-only) and the
//   program loader / debug port (L, read/write).
//
//   Ports
//     clk, reset_n                 clock, asynchronous active-low reset
//     f_req/f_addr                 fetch request (held until f_gnt), byte address
//     f_gnt                        fetch accepted this cycle (combinational)
//     f_rvalid/f_rdata             fetch read result, cycle after f_gnt
//     l_req/l_we/l_lock            loader request, write select, ownership lock
//     l_addr/l_wdata               loader byte address and write data
//     l_gnt                        loader accepted this cycle (combinational)
//     l_rvalid/l_rdata             loader read result, cycle after a read l_gnt
//     err                          one-cycle pulse after a bad-address grant
//     mem_en/mem_we/mem_addr/
//     mem_wdata                    RAM access, driven in the grant cycle
//     mem_rdata                    RAM read data, cycle after a read access
module imem_access_arbiter #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     f_req,
    input  logic [31:0]              f_addr,
    output logic                     f_gnt,
    output logic                     f_rvalid,
    output logic [31:0]              f_rdata,
    input  logic                     l_req,
    input  logic                     l_we,
    input  logic                     l_lock,
    input  logic [31:0]              l_addr,
    input  logic [31:0]              l_wdata,
    output logic                     l_gnt,
    output logic                     l_rvalid,
    output logic [31:0]              l_rdata,
    output logic                     err,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);
    localparam logic [29:0]   DEPTH_W    = 30'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            run_q;
    logic            l_starved;
    logic [31:0]     sel_addr;
    logic            sel_bad;
    logic            f_rd_q, l_rd_q, rd_bad_q, err_q;
    logic [31:0]     f_hold_q, l_hold_q;

    // Misaligned or beyond the last RAM word.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_W);
    endfunction

    // Arbitration and next-state; run_q keeps every grant low until the
    // first clock edge after reset release.
    always_comb begin
        state_d   = state_q;
        f_gnt     = 1'b0;
        l_gnt     = 1'b0;
        l_starved = l_req && (wait_q == WAIT_LIMIT);
        unique case (state_q)
            ST_LOCKED: begin
                if (l_lock) begin
                    l_gnt = l_req && run_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (run_q) begin
                    if (l_starved || (state_q == ST_LOAD && l_lock && l_req)) begin
                        l_gnt = 1'b1;
                    end else if (f_req) begin
                        f_gnt = 1'b1;
                    end else if (l_req) begin
                        l_gnt = 1'b1;
                    end
                end
                if (l_gnt && l_lock) begin
                    state_d = ST_LOCKED;
                end else if (f_gnt) begin
                    state_d = ST_FETCH;
                end else if (l_gnt) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Loader refusal counter, saturating at the starvation limit.
    always_comb begin
        wait_d = wait_q;
        if (l_gnt || !l_req) begin
            wait_d = '0;
        end else if (wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + CW'(1);
        end
    end

    // RAM port driven in the grant cycle; bad addresses never reach the RAM.
    always_comb begin
        sel_addr  = l_gnt ? l_addr : f_addr;
        sel_bad   = addr_bad(sel_addr);
        mem_en    = (f_gnt || l_gnt) && !sel_bad;
        mem_we    = l_gnt && l_we && !sel_bad;
        mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
        mem_wdata = mem_we ? l_wdata : '0;
    end

    // Read return: live RAM data in the valid cycle, last result otherwise.
    always_comb begin
        f_rdata = f_hold_q;
        l_rdata = l_hold_q;
        if (f_rd_q) begin
            f_rdata = rd_bad_q ? 32'h0 : mem_rdata;
        end
        if (l_rd_q) begin
            l_rdata = rd_bad_q ? 32'h0 : mem_rdata;
        end
    end

    assign f_rvalid = f_rd_q;
    assign l_rvalid = l_rd_q;
    assign err      = err_q;

    // State, counter, pending-read tracking and rdata hold registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            run_q    <= 1'b0;
            f_rd_q   <= 1'b0;
            l_rd_q   <= 1'b0;
            rd_bad_q <= 1'b0;
            err_q    <= 1'b0;
            f_hold_q <= '0;
            l_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            run_q    <= 1'b1;
            f_rd_q   <= f_gnt;
            l_rd_q   <= l_gnt && !l_we;
            rd_bad_q <= sel_bad;
            err_q    <= (f_gnt || l_gnt) && sel_bad;
            if (f_rd_q) begin
                f_hold_q <= f_rdata;
            end
            if (l_rd_q) begin
                l_hold_q <= l_rdata;
            end
        end
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Randomized + directed bench for imem_access_arbiter with a rule-level
// arbitration/memory model and read-return scoreboard.
module tb_imem_access_arbiter;

    localparam int unsigned DEPTH    = 64;
    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned AW       = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req = 1'b0;
    logic [31:0]   f_addr = '0;
    logic          f_gnt, f_rvalid;
    logic [31:0]   f_rdata;
    logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0]   l_addr = '0, l_wdata = '0;
    logic          l_gnt, l_rvalid;
    logic [31:0]   l_rdata;
    logic          err, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    imem_access_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Instruction RAM: 1-cycle synchronous read.
    logic [31:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] <= mem_wdata;
                else        mem_rdata <= ram[mem_addr];
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } litem_t;

    logic [31:0] fs[$];
    litem_t      ls[$];
    logic        bound_hit = 1'b0;

    task automatic apply();
        f_req  = (fs.size() != 0);
        f_addr = f_req ? fs[0] : 32'h0;
        if (ls.size() != 0) begin
            l_req = 1'b1; l_we = ls[0].we; l_lock = ls[0].lock;
            l_addr = ls[0].addr; l_wdata = ls[0].wdata;
        end else begin
            l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
        end
    endtask

    // One clock: observe handshakes mid-cycle, retire granted items, drive next.
    task automatic step();
        logic fg, lg;
        @(negedge clk);
        fg = f_gnt;
        lg = l_gnt;
        @(posedge clk);
        #1;
        if (fg && fs.size() != 0) fs.delete(0);
        if (lg && ls.size() != 0) ls.delete(0);
        apply();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((fs.size() != 0 || ls.size() != 0) && n < bound) begin
            step();
            n++;
        end
        if (fs.size() != 0 || ls.size() != 0) begin
            bound_hit = 1'b1;
            fs.delete();
            ls.delete();
            apply();
        end
        repeat (3) step();
    endtask

    task automatic push_l(input logic we, input logic lock, input logic [31:0] a, input logic [31:0] d);
        litem_t it;
        it.we = we; it.lock = lock; it.addr = a; it.wdata = d;
        ls.push_back(it);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
        if (r == 2) return $urandom() & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endfunction

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rexp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    rexp_t       fexp[$], lexp[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_f, last_l;
    int unsigned refused;
    bit          locked, running, err_exp;
    int          owner; // 0 none, 1 F, 2 L (last grant, unlocked)

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        bit          pf, pl, bad;
        logic [31:0] a;
        int          idx;
        rexp_t       e;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_f_gnt", 32'(f_gnt), 0);       chk("rst_l_gnt", 32'(l_gnt), 0);
                chk("rst_f_rvalid", 32'(f_rvalid), 0); chk("rst_l_rvalid", 32'(l_rvalid), 0);
                chk("rst_f_rdata", f_rdata, 0);        chk("rst_l_rdata", l_rdata, 0);
                chk("rst_err", 32'(err), 0);           chk("rst_mem_en", 32'(mem_en), 0);
                chk("rst_mem_we", 32'(mem_we), 0);     chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                fexp.delete(); lexp.delete();
                refused = 0; locked = 0; owner = 0; err_exp = 0; running = 0;
                last_f = '0; last_l = '0;
            end else begin
                // read returns due this cycle
                if (fexp.size() != 0 && fexp[0].due == cyc) begin
                    chk("f_rvalid", 32'(f_rvalid), 1);
                    chk("f_rdata", f_rdata, fexp[0].data);
                    last_f = fexp[0].data;
                    fexp.delete(0);
                end else begin
                    chk("f_rvalid_idle", 32'(f_rvalid), 0);
                    chk("f_rdata_hold", f_rdata, last_f);
                end
                if (lexp.size() != 0 && lexp[0].due == cyc) begin
                    chk("l_rvalid", 32'(l_rvalid), 1);
                    chk("l_rdata", l_rdata, lexp[0].data);
                    last_l = lexp[0].data;
                    lexp.delete(0);
                end else begin
                    chk("l_rvalid_idle", 32'(l_rvalid), 0);
                    chk("l_rdata_hold", l_rdata, last_l);
                end
                chk("err", 32'(err), 32'(err_exp));
                chk("wait_bound", 32'(bound_hit), 0);

                // who should win this cycle
                pf = 0; pl = 0;
                if (!running) begin
                    pf = 0; pl = 0;
                end else if (locked) begin
                    pl = l_lock && l_req;
                end else if (l_req && (refused == MAX_WAIT || (owner == 2 && l_lock))) begin
                    pl = 1;
                end else if (f_req) begin
                    pf = 1;
                end else if (l_req) begin
                    pl = 1;
                end
                chk("f_gnt", 32'(f_gnt), 32'(pf));
                chk("l_gnt", 32'(l_gnt), 32'(pl));

                a   = pl ? l_addr : f_addr;
                bad = (a[1:0] != 2'b00) || (32'(a[31:2]) >= DEPTH);
                idx = bad ? 0 : int'(a[31:2]);
                chk("mem_en", 32'(mem_en), 32'((pf || pl) && !bad));
                chk("mem_we", 32'(mem_we), 32'(pl && l_we && !bad));
                if ((pf || pl) && !bad) chk("mem_addr", 32'(mem_addr), 32'(idx));
                if (pl && l_we && !bad) begin
                    chk("mem_wdata", mem_wdata, l_wdata);
                    ref_mem[idx] = l_wdata;
                end
                if (pf || (pl && !l_we)) begin
                    e.due  = cyc + 1;
                    e.data = bad ? 32'h0 : ref_mem[idx];
                    if (pf) fexp.push_back(e);
                    else    lexp.push_back(e);
                end
                err_exp = (pf || pl) && bad;

                // advance the model past this clock edge
                if (locked) begin
                    if (!l_lock) begin
                        locked = 0;
                        owner  = 0;
                    end
                end else if (pl && l_lock) begin
                    locked = 1;
                end else begin
                    owner = pf ? 1 : (pl ? 2 : 0);
                end
                if (l_req && !pl) refused = (refused < MAX_WAIT) ? refused + 1 : MAX_WAIT;
                else              refused = 0;
                running = 1;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        apply();

        // loader read of word 13 straight after reset
        push_l(0, 0, 32'h34, 0);
        drain(20);

        // back-to-back fetches
        fs.push_back(32'h0); fs.push_back(32'h4); fs.push_back(32'h8);
        drain(20);

        // starvation: both held high
        for (int i = 0; i < 12; i++) fs.push_back(32'(i * 4));
        for (int i = 0; i < 3; i++) push_l(0, 0, 32'h80 + 32'(i * 4), 0);
        drain(60);

        // locked burst with fetch waiting, then fetch reads it back
        for (int i = 0; i < 4; i++) push_l(1, 1, 32'h40 + 32'(i * 4), 32'hE3A0_0000 + 32'(i));
        step();
        step();
        for (int i = 0; i < 4; i++) fs.push_back(32'h40 + 32'(i * 4));
        drain(40);

        // bad addresses
        fs.push_back(32'h2);
        drain(20);
        push_l(1, 0, 32'h100, 32'hDEAD_BEEF);
        drain(20);
        push_l(0, 0, 32'h35, 0);
        drain(20);
        fs.push_back(32'h40);
        drain(20);

        // reset while a fetch read is in flight
        fs.push_back(32'h8);
        apply();
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1;
        fs.delete();
        apply();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            if (fs.size() < 2 && $urandom_range(0, 2) != 0) fs.push_back(rand_addr());
            if (ls.size() == 0 && $urandom_range(0, 3) == 0) begin
                int   n;
                logic lk;
                n  = $urandom_range(1, 4);
                lk = ($urandom_range(0, 2) == 0);
                for (int k = 0; k < n; k++)
                    push_l(1'($urandom_range(0, 1)), lk, rand_addr(), $urandom());
            end
            step();
        end
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
